unary_add_n: RTL and testbench
==============================

Name: unary_add_n

Overview:
- Parametrised successor of the 1-bit unary digit adder: one base-BASE digit accumulated from NUM_IN unary pulse lines plus a carry-in from the lower digit.
- Carry-out chains to the next digit.
- Drain mode serialises the held digit as a unary pulse train on dout, with explicit FSM-driven completion signalling.
- Sits in the unary datapath as one digit slice; several instances chain cin/C to form multi-digit unary counters.

Parameters:
- BASE, 5, digit modulus; count range 0..BASE-1; legal BASE >= 2.
- NUM_IN, 2, number of unary input lines; legal 1 <= NUM_IN <= BASE-1, so at most one carry per cycle.
- CW, $clog2(BASE), derived count width; not to be overridden.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst_n  input  1  reset, synchronous, active-low.
- en  input  1  advance enable; low = all registers hold.
- read_or_write  input  1  0 = accumulate, 1 = drain.
- din  input  NUM_IN  unary pulses; each high bit adds 1 this cycle.
- cin  input  1  carry-in from lower digit; adds 1.
- dout  output  1  registered unary output pulse (drain).
- C  output  1  registered carry-out, high for one cycle per wrap.
- drain_done  output  1  registered one-cycle pulse at drain completion.
- count_o  output  CW  current digit value (registered count).

Behaviour:
- Reset, sampled on clk edge with rst_n=0: count=0, dout=0, C=0, drain_done=0, state=S_ACC. Reset overrides en and takes effect mid-drain.
- en=0: count, state and all outputs hold their values.
- Arithmetic: sum = count + popcount(din) + cin, computed in CW+1 bits; max 2*BASE-1 never overflows.
- Carry: if sum >= BASE then count <= sum-BASE and C <= 1; else count <= sum and C <= 0. One-cycle latency: the carry appears in the cycle after the wrapping inputs.
- FSM states: S_ACC, S_DRAIN, S_DONE.
- S_ACC (read_or_write=0):
  - Performs the arithmetic above.
  - dout <= 0, drain_done <= 0.
  - On read_or_write=1 this cycle (no accumulation performed): if count>0, go to S_DRAIN with the drain action applied this cycle; if count==0, go to S_DONE and set drain_done <= 1, dout <= 0.
- S_DRAIN (read_or_write=1):
  - Each cycle: dout <= 1, count <= count-1, C <= 0.
  - When count==1: go to S_DONE and set drain_done <= 1. drain_done is high in the same cycle as the final dout=1.
- S_DONE (read_or_write=1):
  - dout <= 0, drain_done <= 0, C <= 0, count stays 0.
  - drain_done pulses exactly once per drain.
- Returning to mode 0 from S_DRAIN or S_DONE: go to S_ACC. The accumulate arithmetic applies that same cycle, using the remaining count (a partial drain is not discarded). dout <= 0, drain_done <= 0.
- din and cin are ignored in S_DRAIN and S_DONE.
- count_o always equals count; it is never >= BASE.

Decomposition:
- Shared package unary_pkg:
  - State enum typedef (S_ACC/S_DRAIN/S_DONE).
  - Popcount function, generic in width.
  - Parameter legality checks, as elaboration-time assertions.
- One natural sub-module: unary_popcount (NUM_IN -> CW+1 bits, combinational), reused by other multi-line unary blocks.
- FSM and count register stay in the top level.

Test Plan:
1. Reset and defaults: rst_n=0 for one edge mid-operation with count=3 -> next cycle count_o=0, dout=0, C=0, drain_done=0, state S_ACC.
2. Accumulate with wrap (BASE=5, NUM_IN=2): din=11, 11, then 11 -> count_o 2, 4, then 1 with C=1 for exactly one cycle. din=01 at count 4 -> count 0, C=1.
3. Carry-in chain: count=4, din=00, cin=1 -> count 0, C=1. Two chained instances counting 7 single pulses -> high digit 1, low digit 2.
4. Drain: count=3, read_or_write=1 -> dout=1,1,1,0..., count_o 2,1,0. drain_done=1 only with the third pulse. Draining from count=0 -> dout stays 0, drain_done pulses once.
5. Interrupted drain: count=4, drain 2 cycles, en=0 for 3 cycles (all outputs hold), then read_or_write=0 with din=11 -> count_o=4, no carry. Re-drain gives 4 pulses.
6. Parameter sweep: BASE=2, NUM_IN=1 and BASE=10, NUM_IN=9 with random din/cin vs a reference model -> count_o, C, dout, drain_done match every cycle.

Source files
------------

// File: rtl/unary_pkg.sv
// Shared types and helpers for the unary digit datapath blocks.
package unary_pkg;

  typedef enum logic [1:0] {
    S_ACC,
    S_DRAIN,
    S_DONE
  } state_e;

  // Widest input vector the popcount helper accepts; callers zero-extend.
  localparam int POPCNT_MAX_W = 64;

  function automatic int unsigned popcount(input logic [POPCNT_MAX_W-1:0] v);
    int unsigned n;
    n = 0;
    for (int i = 0; i < POPCNT_MAX_W; i++) begin
      n += int'(v[i]);
    end
    return n;
  endfunction

  // At most one carry per cycle needs NUM_IN <= BASE-1.
  function automatic bit params_legal(input int base, input int num_in);
    return (base >= 2) && (num_in >= 1) && (num_in <= base - 1) &&
           (num_in <= POPCNT_MAX_W);
  endfunction

endpackage

// File: rtl/unary_add_n_if.sv
// Control/data bundle of one unary digit slice.
interface unary_add_n_if #(
  parameter int BASE   = 5,
  parameter int NUM_IN = 2
);
  localparam int CW = $clog2(BASE);

  logic              en;
  logic              read_or_write;
  logic [NUM_IN-1:0] din;
  logic              cin;
  logic              dout;
  logic              C;
  logic              drain_done;
  logic [CW-1:0]     count_o;

  modport master (
    output en, read_or_write, din, cin,
    input  dout, C, drain_done, count_o
  );

  modport slave (
    input  en, read_or_write, din, cin,
    output dout, C, drain_done, count_o
  );
endinterface

// File: rtl/unary_popcount.sv
// Combinational ones-count of NUM_IN unary lines, OW bits wide.
module unary_popcount
  import unary_pkg::*;
#(
  parameter int NUM_IN = 2,
  parameter int OW     = 4
) (
  input  logic [NUM_IN-1:0] din_i,
  output logic [OW-1:0]     cnt_o
);

  assign cnt_o = OW'(popcount(POPCNT_MAX_W'(din_i)));

endmodule

// File: rtl/unary_add_n.sv
// One base-BASE unary digit: accumulates pulses plus carry-in, drains as a pulse train.
module unary_add_n
  import unary_pkg::*;
#(
  parameter int BASE   = 5,
  parameter int NUM_IN = 2
) (
  input logic          clk,
  input logic          rst_n,
  unary_add_n_if.slave bus
);

  localparam int            CW     = $clog2(BASE);
  localparam logic [CW:0]   BASE_W = (CW + 1)'(BASE);
  localparam logic [CW-1:0] ONE    = CW'(1);

  if (!params_legal(BASE, NUM_IN)) begin : g_bad_params
    $error("unary_add_n: illegal BASE/NUM_IN combination");
  end

  state_e        state_q, state_d;
  logic [CW-1:0] count_q, count_d;
  logic          dout_q, dout_d;
  logic          c_q, c_d;
  logic          done_q, done_d;
  logic [CW:0]   pop;
  logic [CW:0]   sum;

  unary_popcount #(
    .NUM_IN(NUM_IN),
    .OW    (CW + 1)
  ) u_popcount (
    .din_i(bus.din),
    .cnt_o(pop)
  );

  // Max sum is 2*BASE-1, which always fits in CW+1 bits.
  assign sum = (CW + 1)'(count_q) + pop + (CW + 1)'(bus.cin);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    dout_d  = dout_q;
    c_d     = c_q;
    done_d  = done_q;
    if (bus.en) begin
      if (!bus.read_or_write) begin
        // Re-entering accumulate keeps whatever a partial drain left behind.
        state_d = S_ACC;
        dout_d  = 1'b0;
        done_d  = 1'b0;
        if (sum >= BASE_W) begin
          count_d = CW'(sum - BASE_W);
          c_d     = 1'b1;
        end else begin
          count_d = CW'(sum);
          c_d     = 1'b0;
        end
      end else begin
        c_d = 1'b0;
        unique case (state_q)
          S_ACC, S_DRAIN: begin
            if (count_q == '0) begin
              state_d = S_DONE;
              dout_d  = 1'b0;
              done_d  = 1'b1;
            end else begin
              dout_d  = 1'b1;
              count_d = count_q - ONE;
              if (count_q == ONE) begin
                state_d = S_DONE;
                done_d  = 1'b1;
              end else begin
                state_d = S_DRAIN;
                done_d  = 1'b0;
              end
            end
          end
          default: begin
            state_d = S_DONE;
            dout_d  = 1'b0;
            done_d  = 1'b0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_ACC;
      count_q <= '0;
      dout_q  <= 1'b0;
      c_q     <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      dout_q  <= dout_d;
      c_q     <= c_d;
      done_q  <= done_d;
    end
  end

  assign bus.dout       = dout_q;
  assign bus.C          = c_q;
  assign bus.drain_done = done_q;
  assign bus.count_o    = count_q;

endmodule

// File: tb/tb_unary_add_n.sv
// Directed checks of the unary digit slice, a two-digit chain and a BASE sweep.
module tb_unary_add_n;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  unary_add_n_if #(.BASE(5),  .NUM_IN(2)) m_if ();
  unary_add_n_if #(.BASE(5),  .NUM_IN(2)) lo_if ();
  unary_add_n_if #(.BASE(5),  .NUM_IN(2)) hi_if ();
  unary_add_n_if #(.BASE(2),  .NUM_IN(1)) b2_if ();
  unary_add_n_if #(.BASE(10), .NUM_IN(9)) b10_if ();

  assign hi_if.cin = lo_if.C;

  unary_add_n #(.BASE(5),  .NUM_IN(2)) u_dut (.clk(clk), .rst_n(rst_n), .bus(m_if.slave));
  unary_add_n #(.BASE(5),  .NUM_IN(2)) u_lo  (.clk(clk), .rst_n(rst_n), .bus(lo_if.slave));
  unary_add_n #(.BASE(5),  .NUM_IN(2)) u_hi  (.clk(clk), .rst_n(rst_n), .bus(hi_if.slave));
  unary_add_n #(.BASE(2),  .NUM_IN(1)) u_b2  (.clk(clk), .rst_n(rst_n), .bus(b2_if.slave));
  unary_add_n #(.BASE(10), .NUM_IN(9)) u_b10 (.clk(clk), .rst_n(rst_n), .bus(b10_if.slave));

  typedef struct packed {
    int cnt;
    int c;
    int dout;
    int done;
    int st;   // 0 accumulate, 1 draining, 2 drained
  } mst_t;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s = %0d", tag, obs);
    end
  endtask

  task automatic exp4(input string tag, input int cnt, input int c, input int dout, input int done);
    check({tag, ".count"}, int'(m_if.count_o), cnt);
    check({tag, ".C"}, int'(m_if.C), c);
    check({tag, ".dout"}, int'(m_if.dout), dout);
    check({tag, ".done"}, int'(m_if.drain_done), done);
  endtask

  task automatic cyc(input logic e, input logic rw, input logic [1:0] d, input logic ci);
    m_if.en            = e;
    m_if.read_or_write = rw;
    m_if.din           = d;
    m_if.cin           = ci;
    @(posedge clk);
    #1;
  endtask

  function automatic mst_t mnext(input mst_t s, input int base, input int pc, input int ci,
                                 input bit rw, input bit en, input bit rstn);
    mst_t n;
    int   sum;
    n = s;
    if (!rstn) return '{0, 0, 0, 0, 0};
    if (!en) return n;
    if (!rw) begin
      sum    = s.cnt + pc + ci;
      n.c    = (sum >= base) ? 1 : 0;
      n.cnt  = (sum >= base) ? sum - base : sum;
      n.dout = 0;
      n.done = 0;
      n.st   = 0;
    end else if (s.st == 2) begin
      n.dout = 0;
      n.done = 0;
      n.c    = 0;
    end else if (s.cnt == 0) begin
      n.st   = 2;
      n.done = 1;
      n.dout = 0;
      n.c    = 0;
    end else begin
      n.cnt  = s.cnt - 1;
      n.dout = 1;
      n.c    = 0;
      n.done = (n.cnt == 0) ? 1 : 0;
      n.st   = (n.cnt == 0) ? 2 : 1;
    end
    return n;
  endfunction

  initial begin
    mst_t s2, s10;
    bit   en2, rw2, ci2, en10, rw10, ci10, rstn;
    logic [0:0] d2;
    logic [8:0] d10;

    rst_n = 1'b0;
    {m_if.en, m_if.read_or_write, m_if.din, m_if.cin} = '0;
    {lo_if.en, lo_if.read_or_write, lo_if.din} = '0;
    {hi_if.en, hi_if.read_or_write, hi_if.din} = '0;
    {b2_if.en, b2_if.read_or_write, b2_if.din, b2_if.cin} = '0;
    {b10_if.en, b10_if.read_or_write, b10_if.din, b10_if.cin} = '0;

    cyc(0, 0, 2'b00, 0);
    cyc(0, 0, 2'b00, 0);
    exp4("por", 0, 0, 0, 0);
    rst_n = 1'b1;

    // Reset while a drain is being requested at count 3
    cyc(1, 0, 2'b11, 0); check("t1.count2", int'(m_if.count_o), 2);
    cyc(1, 0, 2'b01, 0); check("t1.count3", int'(m_if.count_o), 3);
    rst_n = 1'b0;
    cyc(1, 1, 2'b11, 1);
    rst_n = 1'b1;
    exp4("t1.rst", 0, 0, 0, 0);
    cyc(1, 1, 2'b00, 0); exp4("t1.acc_state", 0, 0, 0, 1);
    cyc(1, 0, 2'b00, 0); exp4("t1.back", 0, 0, 0, 0);

    // Accumulate with wrap
    cyc(1, 0, 2'b11, 0); exp4("t2.a", 2, 0, 0, 0);
    cyc(1, 0, 2'b11, 0); exp4("t2.b", 4, 0, 0, 0);
    cyc(1, 0, 2'b11, 0); exp4("t2.wrap", 1, 1, 0, 0);
    cyc(1, 0, 2'b00, 0); exp4("t2.c_once", 1, 0, 0, 0);
    cyc(1, 0, 2'b11, 0); check("t2.d", int'(m_if.count_o), 3);
    cyc(1, 0, 2'b01, 0); exp4("t2.e", 4, 0, 0, 0);
    cyc(1, 0, 2'b01, 0); exp4("t2.wrap1", 0, 1, 0, 0);
    cyc(1, 0, 2'b00, 0); exp4("t2.f", 0, 0, 0, 0);

    // Carry-in, max sum and hold with en low
    cyc(1, 0, 2'b11, 0); cyc(1, 0, 2'b11, 0);
    check("t3.four", int'(m_if.count_o), 4);
    cyc(1, 0, 2'b00, 1); exp4("t3.cin_wrap", 0, 1, 0, 0);
    cyc(1, 0, 2'b11, 1); exp4("t3.three", 3, 0, 0, 0);
    cyc(1, 0, 2'b01, 0); check("t3.four_b", int'(m_if.count_o), 4);
    cyc(1, 0, 2'b11, 1); exp4("t3.max", 2, 1, 0, 0);
    cyc(0, 0, 2'b11, 1); exp4("t3.hold", 2, 1, 0, 0);
    cyc(1, 0, 2'b00, 0); exp4("t3.after", 2, 0, 0, 0);

    // Drain from 3, then drain from 0
    cyc(1, 0, 2'b01, 0); check("t4.three", int'(m_if.count_o), 3);
    cyc(1, 1, 2'b11, 1); exp4("t4.p1", 2, 0, 1, 0);
    cyc(1, 1, 2'b11, 1); exp4("t4.p2", 1, 0, 1, 0);
    cyc(1, 1, 2'b11, 1); exp4("t4.p3", 0, 0, 1, 1);
    cyc(1, 1, 2'b11, 1); exp4("t4.idle1", 0, 0, 0, 0);
    cyc(1, 1, 2'b11, 1); exp4("t4.idle2", 0, 0, 0, 0);
    cyc(1, 0, 2'b00, 0); exp4("t4.acc", 0, 0, 0, 0);
    cyc(1, 1, 2'b00, 0); exp4("t4.zero", 0, 0, 0, 1);
    cyc(1, 1, 2'b00, 0); exp4("t4.zero_idle", 0, 0, 0, 0);
    cyc(1, 0, 2'b00, 0);

    // Interrupted drain resumes from the remaining count
    cyc(1, 0, 2'b11, 0); cyc(1, 0, 2'b11, 0);
    check("t5.four", int'(m_if.count_o), 4);
    cyc(1, 1, 2'b00, 0); exp4("t5.d1", 3, 0, 1, 0);
    cyc(1, 1, 2'b00, 0); exp4("t5.d2", 2, 0, 1, 0);
    for (int i = 0; i < 3; i++) begin
      cyc(0, 1, 2'b11, 1); exp4($sformatf("t5.hold%0d", i), 2, 0, 1, 0);
    end
    cyc(1, 0, 2'b11, 0); exp4("t5.resume", 4, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      cyc(1, 1, 2'b00, 0);
      exp4($sformatf("t5.re%0d", i), 3 - i, 0, 1, (i == 3) ? 1 : 0);
    end
    cyc(1, 1, 2'b00, 0); exp4("t5.end", 0, 0, 0, 0);
    cyc(1, 0, 2'b00, 0);

    // Two chained digits counting 7 single pulses
    lo_if.en = 1'b1; hi_if.en = 1'b1; hi_if.din = 2'b00;
    for (int i = 0; i < 7; i++) begin
      lo_if.din = 2'b01;
      @(posedge clk); #1;
      if (i == 4) check("chain.lo_carry", int'(lo_if.C), 1);
    end
    lo_if.din = 2'b00;
    @(posedge clk); #1;
    check("chain.hi", int'(hi_if.count_o), 1);
    check("chain.lo", int'(lo_if.count_o), 2);
    check("chain.hi_C", int'(hi_if.C), 0);
    lo_if.en = 1'b0; hi_if.en = 1'b0;

    // BASE=2/NUM_IN=1 and BASE=10/NUM_IN=9 against the reference model
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    s2 = '{0, 0, 0, 0, 0};
    s10 = '{0, 0, 0, 0, 0};
    rw2 = 1'b0; rw10 = 1'b0;
    for (int cyc_i = 0; cyc_i < 40; cyc_i++) begin
      rstn = ($urandom_range(0, 29) != 0);
      en2  = ($urandom_range(0, 7) != 0);
      en10 = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 5) == 0) rw2 = ~rw2;
      if ($urandom_range(0, 5) == 0) rw10 = ~rw10;
      ci2  = 1'($urandom_range(0, 1));
      ci10 = 1'($urandom_range(0, 1));
      d2   = 1'($urandom_range(0, 1));
      d10  = 9'($urandom_range(0, 511));
      rst_n = rstn;
      b2_if.en = en2;   b2_if.read_or_write = rw2;   b2_if.din = d2;   b2_if.cin = ci2;
      b10_if.en = en10; b10_if.read_or_write = rw10; b10_if.din = d10; b10_if.cin = ci10;
      s2  = mnext(s2, 2, $countones(d2), int'(ci2), rw2, en2, rstn);
      s10 = mnext(s10, 10, $countones(d10), int'(ci10), rw10, en10, rstn);
      @(posedge clk); #1;
      check($sformatf("b2[%0d].count", cyc_i), int'(b2_if.count_o), s2.cnt);
      check($sformatf("b2[%0d].C", cyc_i), int'(b2_if.C), s2.c);
      check($sformatf("b2[%0d].dout", cyc_i), int'(b2_if.dout), s2.dout);
      check($sformatf("b2[%0d].done", cyc_i), int'(b2_if.drain_done), s2.done);
      check($sformatf("b10[%0d].count", cyc_i), int'(b10_if.count_o), s10.cnt);
      check($sformatf("b10[%0d].C", cyc_i), int'(b10_if.C), s10.c);
      check($sformatf("b10[%0d].dout", cyc_i), int'(b10_if.dout), s10.dout);
      check($sformatf("b10[%0d].done", cyc_i), int'(b10_if.drain_done), s10.done);
    end
    rst_n = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
